execute_stage: RTL
==================

Name: execute_stage

Overview:
- EX stage of the 5-stage 64-bit RISC-V pipeline, directly upstream of memory_stage.
- Resolves operand forwarding, runs the single-cycle ALU, resolves branches and jumps, and runs a shared iterative 64-cycle MUL/DIV/REM unit.
- Registers results into the EX/MEM pipeline register that drives memory_stage's *M inputs.
- Raises StallE while a multi-cycle op is in flight.

Parameters:
- XLEN, 64, datapath width.
- MD_CYCLES, 64, iterations of the mul/div unit. Equals XLEN; not independently tunable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- RegWriteEnE, MemtoRegE, JALE, JALRE, MemReadEnE, MemWriteEnE, BranchE, ALUSrcE  in  1 each  ID/EX control
- MemSizeE, LoadSizeE  in  2 each  store/load size (00 B, 01 H, 10 W)
- BranchTypeE  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- ALUOpE  in  4  ALU operation (encoding below)
- RdE  in  5  destination register
- PcE, PcPlus4E, ImmE, ReadData1E, ReadData2E  in  64 each  ID/EX data
- ForwardAE, ForwardBE  in  2 each  forward select: 00 register, 01 ResultW, 10 ALUResultM, 11 treated as 00
- ResultW  in  64  WB result for forwarding
- FlushE  in  1  squash the instruction currently in EX
- StallE  out  1  hazard unit must hold IF/ID/EX
- PcSrcE  out  1  redirect PC
- PcTargetE  out  64  redirect target
- RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  out  1 each  EX/MEM control
- MemSizeM, LoadSizeM  out  2 each
- RdM  out  5
- PcPlus4M, ReadData2M, ALUResultM  out  64 each

Behaviour:
- Reset: all EX/MEM outputs 0; FSM returns to IDLE; counter 0; StallE 0. Reset is asynchronous and aborts any in-flight op.
- Operand selection:
  - FA and FB come from the forward muxes. ALUResultM forwards from this block's own output register.
  - SrcA = FA. SrcB = ALUSrcE ? ImmE : FB.
  - ReadData2M captures FB.
- ALUOpE encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount SrcB[5:0].
  - 8 SLT, 9 SLTU: result 0 or 1.
  - 10 MUL: low 64 bits.
  - 11 DIV: signed.
  - 12 REM: signed.
  - 13–15: result 0.
- Wrap: all arithmetic is modulo 2^64.
- Branch:
  - Compare FA vs FB per BranchTypeE; undefined types are not taken.
  - PcSrcE = !FlushE & ((BranchE & taken) | JALE | JALRE). Combinational.
  - PcTargetE = JALRE ? ((FA+ImmE) & ~1) : PcE+ImmE.
- Single-cycle ops: on every clock edge where StallE=0, the EX/MEM register loads E controls and data.
- Bubble: when FlushE=1 the register loads a bubble. A bubble is all control outputs 0, RdM 0, and data registers loaded as normal.
- MUL/DIV FSM:
  - States: IDLE, BUSY, DONE.
  - IDLE: if ALUOpE ∈ {10,11,12} and !FlushE, StallE=1 combinationally. Capture |SrcA|, |SrcB|, the signs and the op; counter := 63; go to BUSY. The EX/MEM register loads a bubble.
  - BUSY: StallE=1. One shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle, counter decrements. At counter 0, go to DONE. The EX/MEM register loads a bubble each cycle.
  - DONE: StallE=0. Apply the sign fix:
    - MUL: negate if signs differ.
    - DIV: quotient negated if signs differ.
    - REM: sign of the dividend.
  - In DONE the fixed result replaces the ALU result and the stage loads normally; go to IDLE.
  - Latency: StallE high for 65 cycles; the result is visible on ALUResultM after the 66th edge counted from presentation.
  - Back-to-back MUL/DIV: the second starts from IDLE on the cycle after DONE.
- Divide by zero: quotient all-ones; remainder = SrcA. This overrides the sign fix.
- Overflow: DIV 0x8000_0000_0000_0000 / −1 = 0x8000_0000_0000_0000; REM = 0.
- FlushE during BUSY or DONE: abort to IDLE, StallE=0 that cycle, EX/MEM loads a bubble, no result is written.
- FlushE and a new MUL/DIV in the same cycle: not started; a bubble is loaded.

Test Plan:
- ADD with ForwardAE=10, prior ALUResultM=5, ReadData2E=7, ALUSrcE=0, RdE=3 → next edge ALUResultM=12, RdM=3, RegWriteEnM=1.
- BLT with FA=−1 and FB=1 → PcSrcE=1, PcTargetE=PcE+ImmE. BLTU with the same operands → PcSrcE=0. JALR with FA=0x1001, ImmE=4 → PcTargetE=0x1004.
- MUL −3 × 7:
  - StallE=1 for exactly 65 cycles; RegWriteEnM=0 throughout.
  - Then ALUResultM=0xFFFF_FFFF_FFFF_FFEB (−21).
- DIV/REM:
  - DIV −7/2 → −3; REM −7/2 → −1.
  - DIV 5/0 → all-ones; REM 5/0 → 5.
  - DIV MIN/−1 → MIN.
- FlushE asserted at BUSY cycle 30 of a DIV → StallE drops the same cycle, RegWriteEnM=0, and the next ADD completes normally.
- rst pulsed asynchronously mid-MUL → all outputs 0 immediately, StallE=0, and a subsequent op is correct.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage of the 64-bit RISC-V pipeline: forwarding, ALU, branch resolution,
// iterative MUL/DIV/REM unit and the EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN      = 64,
  parameter int MD_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteEnE,
  input  logic            MemtoRegE,
  input  logic            JALE,
  input  logic            JALRE,
  input  logic            MemReadEnE,
  input  logic            MemWriteEnE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      MemSizeE,
  input  logic [1:0]      LoadSizeE,
  input  logic [2:0]      BranchTypeE,
  input  logic [3:0]      ALUOpE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] PcE,
  input  logic [XLEN-1:0] PcPlus4E,
  input  logic [XLEN-1:0] ImmE,
  input  logic [XLEN-1:0] ReadData1E,
  input  logic [XLEN-1:0] ReadData2E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            StallE,
  output logic            PcSrcE,
  output logic [XLEN-1:0] PcTargetE,
  output logic            RegWriteEnM,
  output logic            MemtoRegM,
  output logic            JALM,
  output logic            MemReadEnM,
  output logic            MemWriteEnM,
  output logic [1:0]      MemSizeM,
  output logic [1:0]      LoadSizeM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PcPlus4M,
  output logic [XLEN-1:0] ReadData2M,
  output logic [XLEN-1:0] ALUResultM
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(MD_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;
  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} mdKind_t;

  mdState_t          state;
  mdKind_t           kind;
  logic [CW-1:0]     cnt;
  logic              negA, negB, divZero;
  logic [XLEN-1:0]   origA, opA, opB, acc;

  logic [XLEN-1:0]   fa, fb, srcA, srcB, aluRes, mdResult, exResult;
  logic [XLEN-1:0]   absA, absB, jalrSum, divDiff;
  logic [XLEN:0]     divSh;
  logic              divFits, taken, isMd, bubble;
  logic [SHW-1:0]    shamt;

  always_comb begin
    fa = ReadData1E;
    case (ForwardAE)
      2'b01:   fa = ResultW;
      2'b10:   fa = ALUResultM;
      default: fa = ReadData1E;
    endcase
    fb = ReadData2E;
    case (ForwardBE)
      2'b01:   fb = ResultW;
      2'b10:   fb = ALUResultM;
      default: fb = ReadData2E;
    endcase
  end

  assign srcA  = fa;
  assign srcB  = ALUSrcE ? ImmE : fb;
  assign shamt = srcB[SHW-1:0];

  always_comb begin
    aluRes = '0;
    case (ALUOpE)
      4'd0: aluRes = srcA + srcB;
      4'd1: aluRes = srcA - srcB;
      4'd2: aluRes = srcA & srcB;
      4'd3: aluRes = srcA | srcB;
      4'd4: aluRes = srcA ^ srcB;
      4'd5: aluRes = srcA << shamt;
      4'd6: aluRes = srcA >> shamt;
      4'd7: aluRes = $signed(srcA) >>> shamt;
      4'd8: aluRes = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      4'd9: aluRes = {{(XLEN-1){1'b0}}, srcA < srcB};
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (BranchTypeE)
      3'b000: taken = (fa == fb);
      3'b001: taken = (fa != fb);
      3'b100: taken = $signed(fa) < $signed(fb);
      3'b101: taken = $signed(fa) >= $signed(fb);
      3'b110: taken = fa < fb;
      3'b111: taken = fa >= fb;
      default: taken = 1'b0;
    endcase
  end

  assign jalrSum   = fa + ImmE;
  assign PcSrcE    = !FlushE & ((BranchE & taken) | JALE | JALRE);
  assign PcTargetE = JALRE ? {jalrSum[XLEN-1:1], 1'b0} : PcE + ImmE;

  assign isMd   = (ALUOpE == 4'd10) || (ALUOpE == 4'd11) || (ALUOpE == 4'd12);
  // Gated by rst so the hazard unit sees no stall while reset is held.
  assign StallE = !rst && !FlushE && (((state == IDLE) && isMd) || (state == BUSY));
  assign bubble = FlushE || StallE;

  assign absA = srcA[XLEN-1] ? '0 - srcA : srcA;
  assign absB = srcB[XLEN-1] ? '0 - srcB : srcB;

  // Restoring division: opA shifts the dividend out while quotient bits shift in.
  assign divSh   = {acc, opA[XLEN-1]};
  assign divFits = divSh >= {1'b0, opB};
  assign divDiff = divSh[XLEN-1:0] - opB;

  always_comb begin
    mdResult = '0;
    case (kind)
      MD_MUL:  mdResult = (negA ^ negB) ? '0 - acc : acc;
      MD_DIV:  mdResult = divZero ? '1 : ((negA ^ negB) ? '0 - opA : opA);
      MD_REM:  mdResult = divZero ? origA : (negA ? '0 - acc : acc);
      default: mdResult = '0;
    endcase
  end

  assign exResult = (state == DONE) ? mdResult : aluRes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      kind    <= MD_MUL;
      cnt     <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      divZero <= 1'b0;
      origA   <= '0;
      opA     <= '0;
      opB     <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isMd && !FlushE) begin
            kind    <= (ALUOpE == 4'd10) ? MD_MUL : ((ALUOpE == 4'd11) ? MD_DIV : MD_REM);
            negA    <= srcA[XLEN-1];
            negB    <= srcB[XLEN-1];
            divZero <= (srcB == '0);
            origA   <= srcA;
            opA     <= absA;
            opB     <= absB;
            acc     <= '0;
            cnt     <= CW'(MD_CYCLES - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (FlushE) begin
            state <= IDLE;
          end else begin
            if (kind == MD_MUL) begin
              if (opB[0]) acc <= acc + opA;
              opA <= opA << 1;
              opB <= opB >> 1;
            end else if (divFits) begin
              acc <= divDiff;
              opA <= {opA[XLEN-2:0], 1'b1};
            end else begin
              acc <= divSh[XLEN-1:0];
              opA <= {opA[XLEN-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteEnM <= 1'b0;
      MemtoRegM   <= 1'b0;
      JALM        <= 1'b0;
      MemReadEnM  <= 1'b0;
      MemWriteEnM <= 1'b0;
      MemSizeM    <= '0;
      LoadSizeM   <= '0;
      RdM         <= '0;
      PcPlus4M    <= '0;
      ReadData2M  <= '0;
      ALUResultM  <= '0;
    end else begin
      RegWriteEnM <= !bubble & RegWriteEnE;
      MemtoRegM   <= !bubble & MemtoRegE;
      JALM        <= !bubble & JALE;
      MemReadEnM  <= !bubble & MemReadEnE;
      MemWriteEnM <= !bubble & MemWriteEnE;
      MemSizeM    <= bubble ? 2'b00 : MemSizeE;
      LoadSizeM   <= bubble ? 2'b00 : LoadSizeE;
      RdM         <= bubble ? 5'd0 : RdE;
      PcPlus4M    <= PcPlus4E;
      ReadData2M  <= fb;
      ALUResultM  <= exResult;
    end
  end

endmodule
